// File: rtl/beta_pkg.sv
// Shared types and register constants for the Beta writeback slice.
package beta_pkg;

  typedef enum logic [1:0] {RD_RC, RD_RB, RD_R31, RD_XP} regdst_e;
  typedef enum logic [1:0] {WD_ALU, WD_LOAD, WD_PC4} wdsel_e;
  typedef enum logic [1:0] {EMPTY, HOLD, WAIT_LD} wb_state_e;

  localparam logic [4:0] REG_LP   = 5'd31;
  localparam logic [4:0] REG_XP   = 5'd1;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/beta_wb_fwd.sv
// Destination resolution, operand forwarding and load-use hazard detect.
// Purely combinational so it can be reused for EX-stage bypass.
module beta_wb_fwd
  import beta_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          hold,
  input  logic          wait_ld,
  input  logic          regwrite,
  input  logic [1:0]    regdst,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rc,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] dec_ra,
  input  logic [AW-1:0] dec_rb,
  input  logic [DW-1:0] rf_radata,
  input  logic [DW-1:0] rf_rbdata,
  output logic          wr_en,
  output logic [DW-1:0] fwd_radata,
  output logic [DW-1:0] fwd_rbdata,
  output logic          ld_hazard
);

  logic [AW-1:0] dest;
  logic          dest_live;

  always_comb begin
    dest = rc;
    case (regdst)
      RD_RC:   dest = rc;
      RD_RB:   dest = rb;
      RD_R31:  dest = AW'(REG_LP);
      RD_XP:   dest = AW'(REG_XP);
      default: dest = rc;
    endcase
  end

  // R0 is hardwired zero: a write to it neither lands nor forwards.
  assign dest_live = regwrite && (dest != AW'(REG_ZERO));
  assign wr_en     = hold && dest_live;

  assign fwd_radata = (wr_en && (dest == dec_ra) && (dec_ra != AW'(REG_ZERO))) ? wdata : rf_radata;
  assign fwd_rbdata = (wr_en && (dest == dec_rb) && (dec_rb != AW'(REG_ZERO))) ? wdata : rf_rbdata;

  assign ld_hazard = wait_ld && dest_live && ((dest == dec_ra) || (dest == dec_rb));

endmodule

// File: rtl/beta_writeback.sv
// Beta writeback stage: holds one retiring instruction, waits on load data,
// drives the register file write port and forwards the in-flight result.
module beta_writeback
  import beta_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic          mem_regwrite,
  input  logic [1:0]    mem_regdst,
  input  logic [AW-1:0] mem_rb,
  input  logic [AW-1:0] mem_rc,
  input  logic [1:0]    mem_wdsel,
  input  logic [DW-1:0] mem_alu,
  input  logic [DW-1:0] mem_pc4,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          RegWrite,
  output logic [1:0]    RegDst,
  output logic [AW-1:0] wb_rb,
  output logic [AW-1:0] wb_rc,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] dec_ra,
  input  logic [AW-1:0] dec_rb,
  input  logic [DW-1:0] rf_radata,
  input  logic [DW-1:0] rf_rbdata,
  output logic [DW-1:0] fwd_radata,
  output logic [DW-1:0] fwd_rbdata,
  output logic          ld_hazard,
  output logic [31:0]   wb_retired
);

  wb_state_e     state;
  logic          h_regwrite;
  logic [1:0]    h_regdst;
  logic [AW-1:0] h_rb;
  logic [AW-1:0] h_rc;
  logic [DW-1:0] h_wdata;
  logic          accept;

  assign mem_ready = (state != WAIT_LD);
  assign accept    = mem_valid && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      h_regwrite <= 1'b0;
      h_regdst   <= '0;
      h_rb       <= '0;
      h_rc       <= '0;
      h_wdata    <= '0;
      wb_retired <= '0;
    end else begin
      // Whatever sat in HOLD this cycle has written and now retires.
      if (state == HOLD)
        wb_retired <= wb_retired + 32'd1;

      case (state)
        WAIT_LD: begin
          if (dmem_rvalid) begin
            h_wdata <= dmem_rdata;
            state   <= HOLD;
          end
        end
        default: begin
          if (accept) begin
            h_regwrite <= mem_regwrite;
            h_regdst   <= mem_regdst;
            h_rb       <= mem_rb;
            h_rc       <= mem_rc;
            if (mem_wdsel == WD_LOAD) begin
              state <= WAIT_LD;
            end else begin
              h_wdata <= (mem_wdsel == WD_PC4) ? mem_pc4 : mem_alu;
              state   <= HOLD;
            end
          end else begin
            state <= EMPTY;
          end
        end
      endcase
    end
  end

  assign RegDst = h_regdst;
  assign wb_rb  = h_rb;
  assign wb_rc  = h_rc;
  assign wdata  = h_wdata;

  beta_wb_fwd #(.DW(DW), .AW(AW)) u_fwd (
    .hold       (state == HOLD),
    .wait_ld    (state == WAIT_LD),
    .regwrite   (h_regwrite),
    .regdst     (h_regdst),
    .rb         (h_rb),
    .rc         (h_rc),
    .wdata      (h_wdata),
    .dec_ra     (dec_ra),
    .dec_rb     (dec_rb),
    .rf_radata  (rf_radata),
    .rf_rbdata  (rf_rbdata),
    .wr_en      (RegWrite),
    .fwd_radata (fwd_radata),
    .fwd_rbdata (fwd_rbdata),
    .ld_hazard  (ld_hazard)
  );

endmodule
